lc3_pipe_ctrl: RTL and testbench

- Central pipeline controller for the LC3 core.
- Sequences the stage enables for fetch, decode, execute and writeback, and computes the execute-stage bypass selects (bypass_alu_1/2, bypass_mem_1/2).
- Runs the data-memory access state machine for LD/LDR/LDI/ST/STR/STI.
- Inserts control-hazard bubbles for BR/JMP and flags a taken branch.
- Sits beside the datapath; its outputs drive the execute input bus and the other stage enables.

---
 rtl/lc3_pipe_ctrl_if.sv | 38 +++
 rtl/lc3_pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_lc3_pipe_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pipe_ctrl_if.sv
// Bundle between the LC3 pipeline controller (master) and the datapath (slave).
// Carries the fetch/execute status inputs and the stage-enable / bypass outputs.
interface lc3_pipe_ctrl_if #(
  parameter int unsigned PERF_W = 16
);
  logic              complete_instr;
  logic              complete_data;
  logic [15:0]       IMem_dout;
  logic [15:0]       IR;
  logic [15:0]       IR_Exec;
  logic [2:0]        psr;
  logic              enable_updatePC;
  logic              enable_fetch;
  logic              enable_decode;
  logic              enable_execute;
  logic              enable_writeback;
  logic              br_taken;
  logic              bypass_alu_1;
  logic              bypass_alu_2;
  logic              bypass_mem_1;
  logic              bypass_mem_2;
  logic [1:0]        mem_state;
  logic [PERF_W-1:0] perf_stall_cnt;

  modport master (
    input  complete_instr, complete_data, IMem_dout, IR, IR_Exec, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
           br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state,
           perf_stall_cnt
  );

  modport slave (
    output complete_instr, complete_data, IMem_dout, IR, IR_Exec, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
           br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state,
           perf_stall_cnt
  );
endinterface

// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline controller: fill sequencing, memory-access FSM, branch bubbles, bypass selects.
// Optional stall counter built only when LC3_CTRL_PERF_EN is defined.
module lc3_pipe_ctrl #(
  parameter int unsigned BR_PENALTY = 3,
  parameter int unsigned PERF_W     = 16
) (
  input logic             clock,
  input logic             reset,
  lc3_pipe_ctrl_if.master bus
);
  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  typedef enum logic [1:0] {
    MemRead  = 2'd0,
    MemInd   = 2'd1,
    MemWrite = 2'd2,
    MemIdle  = 2'd3
  } mem_state_e;

  mem_state_e mem_q, mem_d;
  logic [1:0] fill_q, fill_d;
  logic [2:0] br_cnt_q, br_cnt_d;
  logic       sti_q, sti_d;

  logic en_upd, en_fetch, en_dec, en_exe, en_wb, br_tk;
  logic [3:0] op_ir, op_ex, op_if;
  logic       run;

  assign op_ir = bus.IR[15:12];
  assign op_ex = bus.IR_Exec[15:12];
  assign op_if = bus.IMem_dout[15:12];
  // Nothing advances in reset or while instruction memory has no valid data.
  assign run   = reset & bus.complete_instr;

  always_comb begin
    mem_d    = mem_q;
    fill_d   = fill_q;
    br_cnt_d = br_cnt_q;
    sti_d    = sti_q;
    en_upd   = 1'b0;
    en_fetch = 1'b0;
    en_dec   = 1'b0;
    en_exe   = 1'b0;
    en_wb    = 1'b0;
    br_tk    = 1'b0;
    if (run) begin
      fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
      if (mem_q == MemIdle) begin
        en_fetch = (br_cnt_q == 3'd0);
        en_upd   = (br_cnt_q == 3'd0) || (br_cnt_q == 3'd1);
        en_dec   = (fill_q >= 2'd1);
        en_exe   = (fill_q >= 2'd2);
        en_wb    = (fill_q == 2'd3);
        if (br_cnt_q == 3'd1) begin
          br_tk = (op_ex == OpJmp) || ((op_ex == OpBr) && |(bus.IR_Exec[11:9] & bus.psr));
        end
        if (br_cnt_q != 3'd0) begin
          br_cnt_d = br_cnt_q - 3'd1;
        end else if (en_fetch && ((op_if == OpBr) || (op_if == OpJmp))) begin
          br_cnt_d = 3'(BR_PENALTY);
        end
        if (en_exe) begin
          unique case (op_ir)
            OpLd, OpLdr: mem_d = MemRead;
            OpLdi, OpSti: begin
              mem_d = MemInd;
              sti_d = (op_ir == OpSti);
            end
            OpSt, OpStr: mem_d = MemWrite;
            default: ;
          endcase
        end
      end else begin
        en_wb = (mem_q == MemRead) && bus.complete_data;
        unique case (mem_q)
          MemInd: begin
            if (bus.complete_data) mem_d = sti_q ? MemWrite : MemRead;
          end
          MemRead, MemWrite: begin
            if (bus.complete_data) mem_d = MemIdle;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q    <= MemIdle;
      fill_q   <= 2'd0;
      br_cnt_q <= 3'd0;
      sti_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      fill_q   <= fill_d;
      br_cnt_q <= br_cnt_d;
      sti_q    <= sti_d;
    end
  end

  logic alu_prod, load_prod, src1_hit, src2_hit;

  always_comb begin
    alu_prod  = (op_ex == OpAdd) || (op_ex == OpAnd) || (op_ex == OpNot) || (op_ex == OpLea);
    load_prod = (op_ex == OpLd) || (op_ex == OpLdr) || (op_ex == OpLdi);
    src1_hit  = ((op_ir == OpAdd) || (op_ir == OpAnd) || (op_ir == OpNot) ||
                 (op_ir == OpLdr) || (op_ir == OpStr) || (op_ir == OpJmp)) &&
                (bus.IR_Exec[11:9] == bus.IR[8:6]);
    src2_hit  = (((op_ir == OpAdd) || (op_ir == OpAnd)) && !bus.IR[5] &&
                 (bus.IR_Exec[11:9] == bus.IR[2:0])) ||
                (((op_ir == OpSt) || (op_ir == OpStr) || (op_ir == OpSti)) &&
                 (bus.IR_Exec[11:9] == bus.IR[11:9]));
  end

  // Memory forwarding wins over ALU forwarding on the same operand.
  assign bus.bypass_mem_1 = reset & load_prod & src1_hit;
  assign bus.bypass_mem_2 = reset & load_prod & src2_hit;
  assign bus.bypass_alu_1 = reset & alu_prod & src1_hit & ~bus.bypass_mem_1;
  assign bus.bypass_alu_2 = reset & alu_prod & src2_hit & ~bus.bypass_mem_2;

  assign bus.enable_updatePC  = en_upd;
  assign bus.enable_fetch     = en_fetch;
  assign bus.enable_decode    = en_dec;
  assign bus.enable_execute   = en_exe;
  assign bus.enable_writeback = en_wb;
  assign bus.br_taken         = br_tk;
  assign bus.mem_state        = mem_q;

`ifdef LC3_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_q <= '0;
    end else if ((fill_q == 2'd3) && !en_fetch && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign bus.perf_stall_cnt = perf_q;
`else
  assign bus.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed self-checking bench for lc3_pipe_ctrl; inputs change #1 after posedge,
// outputs are sampled on the falling edge.
module tb_lc3_pipe_ctrl;
  localparam int unsigned PerfW = 16;
`ifdef LC3_CTRL_PERF_EN
  localparam int PerfOn = 1;
`else
  localparam int PerfOn = 0;
`endif

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  lc3_pipe_ctrl_if #(.PERF_W(PerfW)) bus ();

  lc3_pipe_ctrl #(.BR_PENALTY(3), .PERF_W(PerfW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [4:0] en;
  assign en = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
               bus.enable_execute, bus.enable_writeback};

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.complete_instr = 1'b1;
    bus.IR_Exec = 16'h1642;
    bus.IR = 16'h18C5;
    next_cycle();
    next_cycle();
    @(negedge clock);
    n_cmp++;
    if (en !== 5'b00000) begin
      n_bad++; $display("FAIL reset_enables: got %b want 00000", en);
    end
    n_cmp++;
    if (bus.mem_state !== 2'd3) begin
      n_bad++; $display("FAIL reset_mem_state: got %0d want 3", bus.mem_state);
    end
    n_cmp++;
    if ({bus.br_taken, bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1,
         bus.bypass_mem_2} !== 5'b0) begin
      n_bad++; $display("FAIL reset_bypass_br: got %b want 00000",
                        {bus.br_taken, bus.bypass_alu_1, bus.bypass_alu_2,
                         bus.bypass_mem_1, bus.bypass_mem_2});
    end
  endtask

  task automatic test_fill();
    logic [4:0] exp_en [5];
    exp_en = '{5'b11000, 5'b11100, 5'b11110, 5'b11111, 5'b11111};
    bus.IR = 16'h1000;
    bus.IR_Exec = 16'h1000;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++;
      if (en !== exp_en[c]) begin
        n_bad++; $display("FAIL fill_cycle%0d: got %b want %b", c + 1, en, exp_en[c]);
      end
      n_cmp++;
      if (bus.mem_state !== 2'd3) begin
        n_bad++; $display("FAIL fill_mem_state%0d: got %0d want 3", c + 1, bus.mem_state);
      end
      next_cycle();
    end
  endtask

  task automatic test_imem_stall();
    bus.complete_instr = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (en !== 5'b00000) begin
      n_bad++; $display("FAIL imem_stall: got %b want 00000", en);
    end
    next_cycle();
    bus.complete_instr = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (en !== 5'b11111) begin
      n_bad++; $display("FAIL imem_resume: got %b want 11111", en);
    end
    next_cycle();
  endtask

  task automatic test_bypass();
    logic [15:0] v_ex  [6];
    logic [15:0] v_ir  [6];
    logic [3:0]  v_exp [6];
    // expected {alu_1, alu_2, mem_1, mem_2}
    v_ex  = '{16'h1642, 16'h1642, 16'h2600, 16'h1642, 16'h1642, 16'h2600};
    v_ir  = '{16'h18C5, 16'h1943, 16'h18C5, 16'h7640, 16'h1963, 16'h1943};
    v_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0100, 4'b0000, 4'b0001};
    bus.complete_instr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.IR_Exec = v_ex[i];
      bus.IR = v_ir[i];
      #2;
      n_cmp++;
      if ({bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2}
          !== v_exp[i]) begin
        n_bad++; $display("FAIL bypass_%0d: got %b want %b", i,
                          {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1,
                           bus.bypass_mem_2}, v_exp[i]);
      end
    end
    bus.IR = 16'h1000;
    bus.IR_Exec = 16'h1000;
    bus.complete_instr = 1'b1;
    next_cycle();
  endtask

  // LDI: data pulses at cycles 2 and 5; STI: pulses at cycles 2 and 3.
  task automatic test_mem_indirect(input logic is_store);
    logic [1:0] exp_st [5];
    int         n;
    if (is_store) begin
      exp_st = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd3};
      n = 4;
    end else begin
      exp_st = '{2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
      n = 5;
    end
    bus.IR = is_store ? 16'hB600 : 16'hA600;
    bus.complete_data = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (c == 2) bus.IR = 16'h1000;
      bus.complete_data = (c == 2) || (is_store ? (c == 3) : (c == 5));
      @(negedge clock);
      n_cmp++;
      if (bus.mem_state !== exp_st[c-1]) begin
        n_bad++; $display("FAIL %s_state_c%0d: got %0d want %0d", is_store ? "sti" : "ldi",
                          c, bus.mem_state, exp_st[c-1]);
      end
      if (c >= 2 && c <= (is_store ? 3 : 5)) begin
        n_cmp++;
        if (en[4:1] !== 4'b0000 ||
            en[0] !== ((!is_store && c == 5) ? 1'b1 : 1'b0)) begin
          n_bad++; $display("FAIL %s_enables_c%0d: got %b", is_store ? "sti" : "ldi", c, en);
        end
      end
      next_cycle();
    end
    // Data completion while idle must not start anything.
    bus.complete_data = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.mem_state !== 2'd3 || en !== 5'b11111) begin
      n_bad++; $display("FAIL mem_back_idle: got state %0d en %b want 3 11111",
                        bus.mem_state, en);
    end
    next_cycle();
    bus.complete_data = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.mem_state !== 2'd3) begin
      n_bad++; $display("FAIL mem_idle_ignore: got %0d want 3", bus.mem_state);
    end
    next_cycle();
  endtask

  task automatic test_branch(input logic [15:0] br_ir, input logic [2:0] flags,
                             input logic exp_tk);
    bus.IMem_dout = br_ir;
    @(negedge clock);
    n_cmp++;
    if (en !== 5'b11111) begin
      n_bad++; $display("FAIL br_trigger: got %b want 11111", en);
    end
    next_cycle();
    bus.IMem_dout = 16'h1000;
    bus.IR_Exec = br_ir;
    bus.psr = flags;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      n_cmp++;
      if (en !== {(k == 3 || k == 4), (k == 4), 3'b111}) begin
        n_bad++; $display("FAIL br_enables_k%0d: got %b want %b", k, en,
                          {(k == 3 || k == 4), (k == 4), 3'b111});
      end
      n_cmp++;
      if (bus.br_taken !== ((k == 3) && exp_tk)) begin
        n_bad++; $display("FAIL br_taken_k%0d: got %b want %b", k, bus.br_taken,
                          ((k == 3) && exp_tk));
      end
      next_cycle();
    end
    bus.IR_Exec = 16'h1000;
  endtask

  task automatic test_branch_mem();
    bus.IMem_dout = 16'h0405;
    bus.IR = 16'h2600;
    next_cycle();
    bus.IMem_dout = 16'h1000;
    bus.IR = 16'h1000;
    bus.IR_Exec = 16'h0405;
    bus.psr = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      bus.complete_data = (k == 2);
      @(negedge clock);
      n_cmp++;
      if (bus.br_taken !== (k == 5)) begin
        n_bad++; $display("FAIL brmem_taken_k%0d: got %b want %b", k, bus.br_taken, (k == 5));
      end
      n_cmp++;
      if (en[4:3] !== {(k >= 5), (k == 6)} || (k == 2 && en[0] !== 1'b1)) begin
        n_bad++; $display("FAIL brmem_enables_k%0d: got %b", k, en);
      end
      next_cycle();
    end
    bus.complete_data = 1'b0;
    bus.IR_Exec = 16'h1000;
  endtask

  task automatic test_perf_reset();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) next_cycle();
    bus.IR = 16'h2600;
    next_cycle();
    bus.IR = 16'h1000;
    for (int k = 1; k <= 4; k++) begin
      bus.complete_data = (k == 4);
      next_cycle();
    end
    bus.complete_data = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.perf_stall_cnt !== PerfW'(PerfOn * 4)) begin
      n_bad++; $display("FAIL perf_ld4: got %0d want %0d", bus.perf_stall_cnt, PerfOn * 4);
    end
    next_cycle();
    bus.IR = 16'h2600;
    next_cycle();
    bus.IR = 16'h1000;
    @(negedge clock);
    n_cmp++;
    if (bus.mem_state !== 2'd0) begin
      n_bad++; $display("FAIL perf_load_active: got %0d want 0", bus.mem_state);
    end
    next_cycle();
    reset = 1'b0;
    bus.complete_data = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.enable_writeback !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_load_wb: got %b want 0", bus.enable_writeback);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.mem_state !== 2'd3 || bus.perf_stall_cnt !== '0 || bus.enable_writeback !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_load: got state %0d perf %0d wb %b want 3 0 0",
                        bus.mem_state, bus.perf_stall_cnt, bus.enable_writeback);
    end
    bus.complete_data = 1'b0;
    next_cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.complete_instr = 1'b1;
    bus.complete_data = 1'b0;
    bus.IMem_dout = 16'h1000;
    bus.IR = 16'h1000;
    bus.IR_Exec = 16'h1000;
    bus.psr = 3'b000;
    #1;
    test_reset();
    test_fill();
    test_imem_stall();
    test_bypass();
    test_mem_indirect(1'b0);
    test_mem_indirect(1'b1);
    test_branch(16'h0405, 3'b010, 1'b1);
    test_branch(16'h0405, 3'b001, 1'b0);
    test_branch(16'hC1C0, 3'b000, 1'b1);
    test_branch_mem();
    test_perf_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
